c2_demux: RTL and testbench
===========================

# c2_demux

Registered 1-to-4 data distributor that performs the inverse of the C2 logic-cell mux: a single input word is steered into one of four output lanes, selected by the same C2 select decode, S = {A1|B1, A0&B0}. Each lane has a holding register with a valid/ready handshake toward its consumer, and a valid/ready handshake toward the producer. The block sits on the fan-out side of datapaths built from C1/C2 cells and returns words to the lane that a downstream C2 mux would have picked.

## Interface
- SIZE, 5, width of one data word and of each lane.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  SIZE  input word.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block accepts the word this cycle.
- A1, B1, A0, B0  in  1 each  select terms, sampled with in_data.
- out_data  out  4*SIZE  lane k word at bits [k*SIZE +: SIZE].
- out_valid  out  4  bit k set means lane k holds a word.
- out_ready  in  4  bit k set means consumer k takes lane k this cycle.
- lane_count  out  4*8  delivered-word counters; lane k at [k*8 +: 8]. Present only with C2_DEMUX_COUNT_EN.

## Operation
- Lane index S = {A1|B1, A0&B0}: 0 selects lane 0 (D00 position), 1 selects lane 1 (D01), 2 selects lane 2 (D10), 3 selects lane 3 (D11).
- Each lane is a two-state FSM, EMPTY or FULL. Reset state is EMPTY.
- Input transfer is in_valid && in_ready.
- in_ready = !out_valid[S] || out_ready[S]. This is combinational from the current select terms and lane state.
- Output transfer on lane k is out_valid[k] && out_ready[k].
- EMPTY -> FULL on an input transfer targeting k: lane register loads in_data.
- FULL -> EMPTY on an output transfer with no input transfer targeting k.
- FULL -> FULL on a simultaneous output transfer and input transfer to k: register takes the new word and out_valid[k] stays 1.
- FULL, no transfers: out_data lane and out_valid are held stable.
- Lanes are independent. A blocked lane never stalls beats destined for other lanes.
- in_data and the select terms are don't-care when in_valid=0.
- out_data lanes that are EMPTY keep their last value. They are 0 after reset.

## Timing
- Latency: an accepted word is visible on its lane one cycle later, with out_valid set.
- Throughput: one word per cycle while the targeted lane is EMPTY or draining.
- Reset values: out_valid=4'b0000, all out_data=0, lane_count=0, in_ready=1 (all lanes EMPTY).
- rst has priority over every transfer in the same cycle. Words held in any lane are discarded, and a beat presented during reset is not accepted.
- No combinational path from in_valid to out_valid or out_data.
- The only combinational path to in_ready is from out_ready and A1/B1/A0/B0.

## Configuration
- C2_DEMUX_COUNT_EN defined:
  - each lane has an 8-bit counter that increments on every output transfer of that lane;
  - the counter wraps 255 -> 0;
  - it is cleared by rst;
  - values are exposed on lane_count.
- Not defined: no counters and no lane_count port. Behaviour is otherwise identical.

## Structure
- Package c2_pkg holds:
  - lane constants LANE_00=2'd0, LANE_01=2'd1, LANE_10=2'd2, LANE_11=2'd3;
  - COUNT_W=8;
  - function c2_sel(A1,B1,A0,B0) returning the 2-bit S. This function is shared with the C2 mux side so both ends decode identically.
- Sub-module c2_lane: one lane holding register, its EMPTY/FULL state, and the optional counter. It is instantiated four times. The top level holds the select decode and the in_ready mux.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=4'b0000, all out_data=0, no lane loaded, in_ready=1 after reset.
- Decode:
  - in_data=5'd7, A0=1, B0=1, A1=0, B1=0 -> next cycle out_valid=4'b0010, lane 1 = 7;
  - in_data=5'd9, A0=1, B0=0, A1=0, B1=1 -> lane 2 = 9;
  - in_data=5'd3, A0=1, B0=1, A1=1 -> lane 3 = 3.
- Backpressure: lane 3 FULL with out_ready[3]=0, new beat targeting lane 3 -> in_ready=0 and lane 3 data unchanged. A following beat to lane 0 -> in_ready=1, lane 0 loaded.
- Drain+refill: lane 2 FULL with 9, out_ready[2]=1, beat 5'd21 to lane 2 in the same cycle -> out_valid[2] stays 1, lane 2 = 21 next cycle.
- Mid-operation reset: all four lanes FULL, assert rst for one cycle -> next cycle out_valid=4'b0000, all out_data=0.
- With C2_DEMUX_COUNT_EN: 256 output transfers on lane 0 -> lane 0 count reads 255 after the 255th and 0 after the 256th, while other lane counts stay 0.

Source files
------------

// File: rtl/c2_pkg.sv
// Shared C2 definitions: lane constants, widths and the select decode.
package c2_pkg;

  localparam int unsigned SIZE      = 5;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  localparam lane_sel_t LANE_00 = 2'd0;
  localparam lane_sel_t LANE_01 = 2'd1;
  localparam lane_sel_t LANE_10 = 2'd2;
  localparam lane_sel_t LANE_11 = 2'd3;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  typedef struct packed {
    logic [SIZE-1:0] data;
    lane_sel_t       sel;
  } beat_t;

  // Same decode the C2 mux uses, so both ends agree on lane numbering.
  function automatic lane_sel_t c2_sel(input logic a1, input logic b1,
                                       input logic a0, input logic b0);
    return {a1 | b1, a0 & b0};
  endfunction

endpackage

// File: rtl/c2_lane.sv
// One output lane: holding register, EMPTY/FULL state, optional delivery
// counter (C2_DEMUX_COUNT_EN).
module c2_lane
  import c2_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [SIZE-1:0] data_o
`ifdef C2_DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] count_o
`endif
);

  lane_state_e     state_q, state_d;
  logic [SIZE-1:0] data_q,  data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load while FULL only happens when the consumer drains in the same cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      LANE_EMPTY: begin
        if (load_i) begin
          state_d = LANE_FULL;
          data_d  = data_i;
        end
      end
      LANE_FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (ready_i) begin
          state_d = LANE_EMPTY;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  assign valid_o = (state_q == LANE_FULL);
  assign data_o  = data_q;

`ifdef C2_DEMUX_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (valid_o && ready_i) count_d = count_q + COUNT_W'(1);
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/c2_demux.sv
// Registered 1-to-4 distributor steering words by the C2 select decode.
// Optional per-lane delivery counters via C2_DEMUX_COUNT_EN.
module c2_demux
  import c2_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      A1,
  input  logic                      B1,
  input  logic                      A0,
  input  logic                      B0,
  output logic [NUM_LANES*SIZE-1:0] out_data,
  output logic [NUM_LANES-1:0]      out_valid,
  input  logic [NUM_LANES-1:0]      out_ready
`ifdef C2_DEMUX_COUNT_EN
  ,
  output logic [NUM_LANES*COUNT_W-1:0] lane_count
`endif
);

  beat_t                beat_c;
  logic                 accept_c;
  logic [NUM_LANES-1:0] load_c;

  assign beat_c.data = in_data;
  assign beat_c.sel  = c2_sel(A1, B1, A0, B0);

  // Ready depends only on the targeted lane, so other lanes never stall.
  assign in_ready = !out_valid[beat_c.sel] || out_ready[beat_c.sel];
  assign accept_c = in_valid && in_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign load_c[k] = accept_c && (beat_c.sel == lane_sel_t'(k));

    c2_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_c[k]),
      .data_i  (beat_c.data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*SIZE +: SIZE])
`ifdef C2_DEMUX_COUNT_EN
      ,
      .count_o (lane_count[k*COUNT_W +: COUNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_c2_demux.sv
// Scoreboard bench for c2_demux: per-lane expected-word queues, directed
// cases plus random traffic; counter checks when C2_DEMUX_COUNT_EN is defined.
module tb_c2_demux;

  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          A1, B1, A0, B0;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
`ifdef C2_DEMUX_COUNT_EN
  logic [31:0]   lane_count;
`endif

  c2_demux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef C2_DEMUX_COUNT_EN
    , .lane_count(lane_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words waiting in each lane, last word loaded, deliveries.
  logic [W-1:0] lane_q [4][$];
  logic [W-1:0] last_word [4];
  int           deliv [4];
  int           lane0_pops;

  // Beat the stimulus expects to be accepted at the coming edge.
  bit           pend_v;
  int           pend_lane;
  logic [W-1:0] pend_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
  endtask

  function automatic int lane_of(input logic a1, input logic b1, input logic a0, input logic b0);
    return ((a1 || b1) ? 2 : 0) + ((a0 && b0) ? 1 : 0);
  endfunction

  function automatic bit model_ready(input int s);
    return (lane_q[s].size() == 0) || out_ready[s];
  endfunction

  // Monitor: compare outputs against the model, then retire/append words.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        lane_q[k].delete();
        last_word[k] = '0;
        deliv[k] = 0;
      end
      pend_v = 0;
    end else begin
      logic [3:0] ev;
      int s;
      s = lane_of(A1, B1, A0, B0);
      chk("in_ready", 32'(in_ready), 32'(model_ready(s)));
      for (int k = 0; k < 4; k++) ev[k] = (lane_q[k].size() != 0);
      chk("out_valid", 32'(out_valid), 32'(ev));
      for (int k = 0; k < 4; k++) begin
        logic [W-1:0] wd;
        wd = ev[k] ? lane_q[k][0] : last_word[k];
        chk($sformatf("lane%0d_data", k), 32'(out_data[k*W +: W]), 32'(wd));
`ifdef C2_DEMUX_COUNT_EN
        chk($sformatf("lane%0d_count", k), 32'(lane_count[k*8 +: 8]), 32'(deliv[k] % 256));
`endif
      end
      for (int k = 0; k < 4; k++) begin
        if (ev[k] && out_ready[k]) begin
          void'(lane_q[k].pop_front());
          deliv[k]++;
          if (k == 0) lane0_pops++;
        end
      end
      if (pend_v) begin
        lane_q[pend_lane].push_back(pend_data);
        last_word[pend_lane] = pend_data;
        pend_v = 0;
      end
    end
  end

  // Drive one cycle of stimulus just after the edge and post the expected beat.
  task automatic drive(input bit r, input bit v, input logic [W-1:0] d,
                       input logic a1, input logic b1, input logic a0, input logic b0,
                       input logic [3:0] ordy);
    int s;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d;
    A1 = a1; B1 = b1; A0 = a0; B0 = b0; out_ready = ordy;
    s = lane_of(a1, b1, a0, b0);
    if (!r && v && model_ready(s)) begin
      pend_v = 1; pend_lane = s; pend_data = d;
    end
  endtask

  // Observe the state produced by the previous drive call.
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input logic [3:0] ordy);
    drive(0, 0, '0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    rst = 1; in_valid = 1; in_data = 5'd31; A1 = 1; B1 = 1; A0 = 1; B0 = 1;
    out_ready = '0; pend_v = 0; lane0_pops = 0;

    // Reset held 2 cycles with a beat presented
    drive(1, 1, 5'd31, 1, 1, 1, 1, 4'b0000);
    drive(1, 1, 5'd31, 1, 1, 1, 1, 4'b0000);
    drive(0, 0, 5'd0, 0, 0, 0, 0, 4'b0000);
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);

    // Decode
    drive(0, 1, 5'd7, 0, 0, 1, 1, 4'b0000);
    idle(4'b0000); #2;
    chk("dec_lane1_v", 32'(out_valid), 32'b0010);
    chk("dec_lane1_d", 32'(out_data[1*W +: W]), 32'd7);
    drive(0, 1, 5'd9, 0, 1, 1, 0, 4'b0000);
    idle(4'b0000); #2;
    chk("dec_lane2_v", 32'(out_valid), 32'b0110);
    chk("dec_lane2_d", 32'(out_data[2*W +: W]), 32'd9);
    drive(0, 1, 5'd3, 1, 0, 1, 1, 4'b0000);
    idle(4'b0000); #2;
    chk("dec_lane3_v", 32'(out_valid), 32'b1110);
    chk("dec_lane3_d", 32'(out_data[3*W +: W]), 32'd3);

    // Backpressure on lane 3, lane 0 still flows
    drive(0, 1, 5'd17, 1, 1, 1, 1, 4'b0000);
    #1;
    chk("bp_ready", 32'(in_ready), 32'h0);
    drive(0, 1, 5'd12, 0, 0, 0, 0, 4'b0000);
    #1;
    chk("bp_lane0_ready", 32'(in_ready), 32'h1);
    idle(4'b0000); #2;
    chk("bp_lane3_held", 32'(out_data[3*W +: W]), 32'd3);
    chk("bp_lane0_d", 32'(out_data[0*W +: W]), 32'd12);
    chk("bp_all_full", 32'(out_valid), 32'b1111);

    // Drain and refill lane 2 in one cycle
    drive(0, 1, 5'd21, 1, 0, 0, 1, 4'b0100);
    #1;
    chk("refill_ready", 32'(in_ready), 32'h1);
    idle(4'b0000); #2;
    chk("refill_valid", 32'(out_valid[2]), 32'h1);
    chk("refill_data", 32'(out_data[2*W +: W]), 32'd21);

    // Mid-operation reset with all lanes full
    drive(1, 1, 5'd5, 0, 0, 0, 0, 4'b0000);
    idle(4'b0000); #2;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_data", 32'(out_data), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom));
    end

`ifdef C2_DEMUX_COUNT_EN
    // Counter wrap on lane 0
    drive(1, 0, '0, 0, 0, 0, 0, 4'b0000);
    idle(4'b0000);
    lane0_pops = 0;
    begin
      bit seen255 = 0;
      for (int i = 0; i < 257; i++) begin
        drive(0, (i < 256), W'(i), 0, 0, 0, 0, 4'b0001);
        #2;
        if (lane0_pops == 255 && !seen255) begin
          chk("cnt_255", 32'(lane_count[7:0]), 32'd255);
          seen255 = 1;
        end
      end
      idle(4'b0000); #2;
      chk("cnt_seen255", 32'(seen255), 32'h1);
      chk("cnt_wrap", 32'(lane_count), 32'h0);
    end
`endif

    // Drain everything left
    for (int i = 0; i < 4; i++) idle(4'b1111);
    idle(4'b0000); #2;
    chk("final_empty", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
